// File: rtl/output_buffer_pkg.sv
// rtl/output_buffer_pkg.sv - shared SNN geometry, core state encodings and output buffer widths
package output_buffer_pkg;

    localparam int N_SZ      = 5;
    localparam int G_SZ      = 2;
    localparam int N_NUM     = 1 << N_SZ;
    localparam int G_NUM     = 1 << G_SZ;
    localparam int ADDR_W    = N_SZ + G_SZ;
    localparam int DATA_W    = 32;
    localparam int OUT_W     = 16;
    localparam int MAX_WORDS = 1 << ADDR_W;

    // Core sequencing states, shared with the input buffer so start can be gated on CORE_DONE.
    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_LOAD,
        CORE_RUN,
        CORE_DONE
    } core_state_t;

endpackage

// File: rtl/output_buffer_halfword_serializer.sv
// rtl/output_buffer_halfword_serializer.sv - presents a loaded word as low then high halfword under valid/ready
module output_buffer_halfword_serializer
    import output_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [OUT_W-1:0]  hw_out,
    output logic              valid,
    input  logic              ready,
    output logic              word_done
);

    // The low half goes straight to hw_out on load, so only the high half needs holding.
    logic [DATA_W-OUT_W-1:0] hi_data;
    logic                    hi_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_data  <= '0;
            hi_phase <= 1'b0;
            valid    <= 1'b0;
            hw_out   <= '0;
        end else if (load) begin
            hi_data  <= din[DATA_W-1:OUT_W];
            hw_out   <= din[OUT_W-1:0];
            valid    <= 1'b1;
            hi_phase <= 1'b0;
        end else if (valid && ready) begin
            if (!hi_phase) begin
                hw_out   <= hi_data;
                hi_phase <= 1'b1;
            end else begin
                valid    <= 1'b0;
                hi_phase <= 1'b0;
            end
        end
    end

    assign word_done = valid && ready && hi_phase;

endmodule

// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - reads result words from neuron SRAM and streams them out as halfwords
module output_buffer
    import output_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    output logic              rd_en,
    output logic [ADDR_W-1:0] output_addr,
    input  logic [DATA_W-1:0] DOUT,
    output logic [OUT_W-1:0]  ext_out,
    output logic              ext_valid,
    input  logic              ext_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND_LO,
        SEND_HI,
        FINISH
    } ob_state_t;

    ob_state_t         state;
    logic [ADDR_W-1:0] last_addr;
    logic              word_done;
    logic              load;

    // SRAM data is valid during WAIT, so the serializer captures it on the edge leaving WAIT.
    assign load = (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            output_addr <= '0;
            last_addr   <= '0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_words == '0) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            // Counts of 128 and above all end at the top address.
                            last_addr   <= num_words[ADDR_W] ? {ADDR_W{1'b1}}
                                                             : num_words[ADDR_W-1:0] - ADDR_W'(1);
                            output_addr <= '0;
                            rd_en       <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                REQ:     state <= WAIT;
                WAIT:    state <= SEND_LO;
                SEND_LO: if (ext_ready) state <= SEND_HI;
                SEND_HI: begin
                    if (word_done) begin
                        if (output_addr == last_addr) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            output_addr <= output_addr + ADDR_W'(1);
                            rd_en       <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    output_buffer_halfword_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (DOUT),
        .hw_out    (ext_out),
        .valid     (ext_valid),
        .ready     (ext_ready),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - scoreboard bench for output_buffer
module tb_output_buffer;
    import output_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              rd_en;
    logic [ADDR_W-1:0] output_addr;
    logic [DATA_W-1:0] dout;
    logic [OUT_W-1:0]  ext_out;
    logic              ext_valid;
    logic              ext_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [MAX_WORDS];
    logic [OUT_W-1:0]  exp_q [$];
    int                checks = 0;
    int                errors = 0;
    int                ready_mode = 0;
    logic              prev_stall = 1'b0;
    logic [OUT_W-1:0]  prev_out = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) dout <= mem[output_addr];

    output_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_words   (num_words),
        .rd_en       (rd_en),
        .output_addr (output_addr),
        .DOUT        (dout),
        .ext_out     (ext_out),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drives ext_ready at each falling edge and checks every handshake that the next rising edge will take.
    task automatic monitor();
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       ext_ready = 1'b0;
                1:       ext_ready = 1'b1;
                default: ext_ready = 1'($urandom_range(0, 1));
            endcase
            if (ext_valid) begin
                if (prev_stall) check("hold_stable", 32'(ext_out), 32'(prev_out));
                prev_stall = !ext_ready;
                prev_out   = ext_out;
                if (ext_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_halfword: got 0x%0h expected none", ext_out);
                    end else begin
                        check("halfword", 32'(ext_out), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    task automatic push_words(input int n);
        int m;
        m = (n > MAX_WORDS) ? MAX_WORDS : n;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(mem[i][15:0]);
            exp_q.push_back(mem[i][31:16]);
        end
    endtask

    task automatic run(input int n, input int budget, input int exp_done, input int exp_rd,
                       input int exp_max, input int repulse_k);
        int done_cyc = 0;
        int rd_cnt = 0;
        int max_addr = -1;
        @(negedge clk);
        start = 1'b1;
        num_words = n[ADDR_W:0];
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = (k == repulse_k);
            if (start) num_words = 5;
            if (rd_en) begin
                rd_cnt++;
                if (int'(output_addr) > max_addr) max_addr = int'(output_addr);
            end
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done_cyc != 0), 32'd1);
        if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
        check("rd_count", rd_cnt, exp_rd);
        check("max_addr", max_addr, exp_max);
        @(negedge clk);
        check("busy_low_after", 32'(busy), 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic stimulus();
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        num_words = '0;
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_valid", 32'(ext_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ext_out", 32'(ext_out), 0);
        rst = 1'b0;

        // Reset in the middle of SEND_LO discards the word.
        mem[0] = 32'h1111_2222;
        mem[1] = 32'h3333_4444;
        ready_mode = 0;
        @(negedge clk);
        start = 1'b1;
        num_words = 2;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ext_valid) begin
                seen = 1;
                break;
            end
        end
        check("sendlo_reached", 32'(seen), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_rd_en", 32'(rd_en), 0);
        check("midrst_valid", 32'(ext_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_addr", 32'(output_addr), 0);
        rst = 1'b0;
        ready_mode = 1;
        repeat (6) begin
            @(negedge clk);
            check("postrst_idle", {30'd0, rd_en, ext_valid}, 0);
        end

        // Single word, exact cycle timing.
        mem[0] = 32'hDEAD_BEEF;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hDEAD);
        @(negedge clk);
        start = 1'b1;
        num_words = 1;
        @(negedge clk);
        start = 1'b0;
        check("c1_rd_en", 32'(rd_en), 1);
        check("c1_addr", 32'(output_addr), 0);
        check("c1_busy", 32'(busy), 1);
        @(negedge clk);
        check("c2_rd_en", 32'(rd_en), 0);
        check("c2_valid", 32'(ext_valid), 0);
        @(negedge clk);
        check("c3_valid", 32'(ext_valid), 1);
        check("c3_out", 32'(ext_out), 32'h0000_BEEF);
        @(negedge clk);
        check("c4_valid", 32'(ext_valid), 1);
        check("c4_out", 32'(ext_out), 32'h0000_DEAD);
        @(negedge clk);
        check("c5_done", 32'(done), 1);
        check("c5_busy", 32'(busy), 1);
        check("c5_valid", 32'(ext_valid), 0);
        @(negedge clk);
        check("c6_done", 32'(done), 0);
        check("c6_busy", 32'(busy), 0);
        check("c6_hold_out", 32'(ext_out), 32'h0000_DEAD);

        // Backpressure with random ready.
        mem[0] = 32'h0002_0001;
        mem[1] = 32'h0004_0003;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0004);
        ready_mode = 2;
        run(2, 400, 0, 2, 1, 0);
        ready_mode = 1;

        // Full sweep.
        for (int i = 0; i < MAX_WORDS; i++) mem[i] = i * 32'h0001_0001;
        push_words(128);
        run(128, 700, 128 * 4 + 1, 128, 127, 0);

        // Zero words.
        run(0, 10, 1, 0, -1, 0);

        // Start re-pulsed while busy has no effect.
        push_words(2);
        run(2, 40, 9, 2, 1, 3);

        // Oversized count clamps to 128.
        push_words(200);
        run(200, 700, 128 * 4 + 1, 128, 127, 0);
    endtask

    initial begin
        ext_ready = 1'b0;
        fork
            monitor();
            stimulus();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
